// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//   Writable instruction memory. A host streams a program in, one byte per
//   transfer. The core fetches through a combinational read port.
//
//   Handshake: a byte is taken on a rising edge when in_valid && in_ready.
//   in_ready is high only in LOAD. It does not depend on in_valid. The host
//   holds in_data stable while in_valid is high and the byte is not taken.
//
//   Ports
//     clk, reset_n        clock and synchronous active-low reset
//     load_start/load_len begin a load of load_len bytes (accepted in IDLE)
//     load_abort          abandon an in-progress load
//     in_data/in_valid    byte stream from host; in_ready = accept
//     busy, done, error   status; done pulses once per completed load
//     load_count          bytes written by the current or last load
//     checksum            byte sum of the current or last load (optional)
//     rd_address          fetch address in
//     rd_instruction      fetch data out (combinational)
//     state_dbg           encoded FSM state: 0 IDLE, 1 LOAD, 2 DONE
//
//   Optional build macro: IMEM_LOADER_CHECKSUM_EN enables the checksum adder.
//   When the macro is undefined, checksum is tied to zero.
// -----------------------------------------------------------------------------
module imem_loader #(
   parameter int DEPTH  = 32,
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              load_start,
   input  logic [ADDR_W-1:0] load_len,
   input  logic              load_abort,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [ADDR_W-1:0] load_count,
   output logic [DATA_W-1:0] checksum,
   input  logic [ADDR_W-1:0] rd_address,
   output logic [DATA_W-1:0] rd_instruction,
   output logic [1:0]        state_dbg
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   // DEPTH is held one bit wider than an address, so DEPTH == 2**ADDR_W still compares correctly.
   localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] len_q, len_d;
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] load_count_q, load_count_d;
   logic              error_q, error_d;
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   logic              xfer;
   logic              len_ok;

   assign len_ok = (load_len != '0) && ({1'b0, load_len} <= DEPTH_W);
   assign xfer   = (state_q == LOAD) && in_valid && !load_abort;

   always_comb begin
      state_d      = state_q;
      len_d        = len_q;
      wr_ptr_d     = wr_ptr_q;
      load_count_d = load_count_q;
      error_d      = error_q;
      mem_d        = mem_q;
      unique case (state_q)
         IDLE: begin
            if (load_start) begin
               if (len_ok) begin
                  len_d        = load_len;
                  wr_ptr_d     = '0;
                  load_count_d = '0;
                  error_d      = 1'b0;
                  state_d      = LOAD;
               end else begin
                  error_d = 1'b1;
               end
            end
         end
         LOAD: begin
            // Abort takes priority: a byte offered in the abort cycle is dropped.
            if (load_abort) begin
               state_d = IDLE;
            end else if (in_valid) begin
               mem_d[wr_ptr_q[IDX_W-1:0]] = in_data;
               wr_ptr_d     = wr_ptr_q + 1'b1;
               load_count_d = load_count_q + 1'b1;
               if (wr_ptr_q == len_q - 1'b1) state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         len_q        <= '0;
         wr_ptr_q     <= '0;
         load_count_q <= '0;
         error_q      <= 1'b0;
         mem_q        <= '{default: '0};
      end else begin
         state_q      <= state_d;
         len_q        <= len_d;
         wr_ptr_q     <= wr_ptr_d;
         load_count_q <= load_count_d;
         error_q      <= error_d;
         mem_q        <= mem_d;
      end
   end

`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [DATA_W-1:0] checksum_q, checksum_d;

   always_comb begin
      checksum_d = checksum_q;
      if (state_q == IDLE && load_start && len_ok) checksum_d = '0;
      else if (xfer)                                checksum_d = checksum_q + in_data;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) checksum_q <= '0;
      else          checksum_q <= checksum_d;
   end

   assign checksum = checksum_q;
`else
   assign checksum = '0;
`endif

   // Addresses outside the array read as zero so a runaway fetch sees a known value.
   always_comb begin
      rd_instruction = '0;
      if ({1'b0, rd_address} < DEPTH_W) rd_instruction = mem_q[rd_address[IDX_W-1:0]];
   end

   assign in_ready   = (state_q == LOAD);
   assign busy       = (state_q == LOAD);
   assign done       = (state_q == DONE);
   assign error      = error_q;
   assign load_count = load_count_q;
   assign state_dbg  = state_q;

endmodule
